// File: rtl/axi_default_slave_burst_pkg.sv
// Shared types and constants for the AXI default (decode-error) slave.
//   RESP_DECERR : response code returned on every R beat and B response
//   rd_state_e  : read engine states
//   wr_state_e  : write engine states
package axi_default_slave_burst_pkg;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axi_default_slave_burst_if.sv
// AXI channel bundle seen by the default slave (AR, R, AW, W, B).
//   slave  modport : used by axi_default_slave_burst
//   master modport : used by the interconnect side / testbench
// WDATA/WSTRB are not carried: the default slave discards write data.
interface axi_default_slave_burst_if #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) ();
    // read address
    logic [ID_W-1:0]   arid;
    logic [31:0]       araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    // read data
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    // write address
    logic [ID_W-1:0]   awid;
    logic [31:0]       awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready;
    // write data
    logic              wlast;
    logic              wvalid;
    logic              wready;
    // write response
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport slave (
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_default_slave_burst_cmd_fifo.sv
// ds_cmd_fifo: small synchronous command FIFO holding {id, len} for one direction.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write din (ignored when full)
//   pop      : drop head (ignored when empty)
//   full     : registered, DEPTH entries held
//   empty    : registered, no entries held
//   head     : oldest entry, valid while !empty
module ds_cmd_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign head    = mem[rd_ptr];

    // Pointer, occupancy and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_default_slave_burst.sv
// axi_default_slave_burst: AXI default slave answering every request with DECERR.
//   clk, rst : clock, synchronous active-high reset (drops in-flight bursts)
//   bus      : AXI AR/R/AW/W/B channels (slave modport)
// Optional build macro DS_ERR_LOG_EN adds:
//   err_cnt[15:0]     : saturating count of accepted AR+AW commands
//   err_addr[31:0]    : address of the most recently accepted command (AW wins ties)
//   err_is_wr         : 1 when err_addr came from AW
//   err_wlen_mismatch : sticky, a write burst's beat count differed from awlen+1
// Read and write engines are independent; each buffers OST_DEPTH commands.
module axi_default_slave_burst
    import axi_default_slave_burst_pkg::*;
#(
    parameter int unsigned ID_W      = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned OST_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DS_ERR_LOG_EN
    output logic [15:0] err_cnt,
    output logic [31:0] err_addr,
    output logic        err_is_wr,
    output logic        err_wlen_mismatch,
`endif
    axi_default_slave_burst_if.slave bus
);

    localparam int unsigned CMD_W = ID_W + LEN_W;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
    } cmd_t;

    // ---------------- command FIFOs ----------------
    cmd_t ar_din, ar_head, aw_din, aw_head;
    logic ar_full, ar_empty, ar_push, ar_pop;
    logic aw_full, aw_empty, aw_push, aw_pop;

    assign bus.arready = !ar_full;
    assign bus.awready = !aw_full;
    assign ar_push     = bus.arvalid && !ar_full;
    assign aw_push     = bus.awvalid && !aw_full;
    assign ar_din      = '{id: bus.arid, len: bus.arlen};
    assign aw_din      = '{id: bus.awid, len: bus.awlen};

    ds_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(OST_DEPTH)) u_ar_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ar_push),
        .pop   (ar_pop),
        .din   (ar_din),
        .full  (ar_full),
        .empty (ar_empty),
        .head  (ar_head)
    );

    ds_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(OST_DEPTH)) u_aw_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_push),
        .pop   (aw_pop),
        .din   (aw_din),
        .full  (aw_full),
        .empty (aw_empty),
        .head  (aw_head)
    );

    // ---------------- read engine ----------------
    rd_state_e        rd_state, rd_state_n;
    logic [ID_W-1:0]  rid_q, rid_n;
    logic [LEN_W-1:0] rlen_q, rlen_n;
    logic [LEN_W-1:0] beat_q, beat_n;
    logic             rvalid_q, rvalid_n;
    logic             rlast_q, rlast_n;
    logic             r_fire;

    assign r_fire = rvalid_q && bus.rready;

    // Read state register and registered R outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rid_q    <= '0;
            rlen_q   <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            rid_q    <= rid_n;
            rlen_q   <= rlen_n;
            beat_q   <= beat_n;
            rvalid_q <= rvalid_n;
            rlast_q  <= rlast_n;
        end
    end

    // Read next-state: load head command, then stream len+1 beats
    always_comb begin
        rd_state_n = rd_state;
        rid_n      = rid_q;
        rlen_n     = rlen_q;
        beat_n     = beat_q;
        rvalid_n   = rvalid_q;
        rlast_n    = rlast_q;
        ar_pop     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (!ar_empty) begin
                    rd_state_n = R_BURST;
                    ar_pop     = 1'b1;
                    rid_n      = ar_head.id;
                    rlen_n     = ar_head.len;
                    beat_n     = '0;
                    rvalid_n   = 1'b1;
                    rlast_n    = (ar_head.len == '0);
                end
            end
            R_BURST: begin
                if (r_fire) begin
                    if (rlast_q) begin
                        rd_state_n = R_IDLE;
                        rvalid_n   = 1'b0;
                        rlast_n    = 1'b0;
                    end else begin
                        // beat_q stops at len, so an all-ones len never wraps
                        beat_n  = beat_q + LEN_W'(1);
                        rlast_n = ((beat_q + LEN_W'(1)) == rlen_q);
                    end
                end
            end
            default: begin
                rd_state_n = R_IDLE;
                rvalid_n   = 1'b0;
                rlast_n    = 1'b0;
            end
        endcase
    end

    assign bus.rid   = rid_q;
    assign bus.rdata = '0;
    assign bus.rresp = RESP_DECERR;
    assign bus.rlast = rlast_q;
    assign bus.rvalid = rvalid_q;

    // ---------------- write engine ----------------
    wr_state_e       wr_state, wr_state_n;
    logic [ID_W-1:0] bid_q, bid_n;
    logic            wready_q, wready_n;
    logic            bvalid_q, bvalid_n;
    logic            w_fire;
    logic            b_fire;

    assign w_fire = wready_q && bus.wvalid;
    assign b_fire = bvalid_q && bus.bready;

    // Write state register and registered W/B outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            bid_q    <= '0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            wr_state <= wr_state_n;
            bid_q    <= bid_n;
            wready_q <= wready_n;
            bvalid_q <= bvalid_n;
        end
    end

    // Write next-state: take AW, sink beats until wlast, then one B
    always_comb begin
        wr_state_n = wr_state;
        bid_n      = bid_q;
        wready_n   = wready_q;
        bvalid_n   = bvalid_q;
        aw_pop     = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (!aw_empty) begin
                    wr_state_n = W_DATA;
                    aw_pop     = 1'b1;
                    bid_n      = aw_head.id;
                    wready_n   = 1'b1;
                end
            end
            W_DATA: begin
                if (w_fire && bus.wlast) begin
                    wr_state_n = W_RESP;
                    wready_n   = 1'b0;
                    bvalid_n   = 1'b1;
                end
            end
            W_RESP: begin
                if (b_fire) begin
                    wr_state_n = W_IDLE;
                    bvalid_n   = 1'b0;
                end
            end
            default: begin
                wr_state_n = W_IDLE;
                wready_n   = 1'b0;
                bvalid_n   = 1'b0;
            end
        endcase
    end

    assign bus.wready = wready_q;
    assign bus.bid    = bid_q;
    assign bus.bresp  = RESP_DECERR;
    assign bus.bvalid = bvalid_q;

`ifdef DS_ERR_LOG_EN
    // ---------------- error log ----------------
    logic [LEN_W-1:0] wlen_q;
    logic [LEN_W+1:0] wbeats_q;
    logic [1:0]       log_inc;
    logic [16:0]      cnt_sum;

    assign log_inc = 2'(ar_push) + 2'(aw_push);
    assign cnt_sum = {1'b0, err_cnt} + 17'(log_inc);

    // Command counter, last address and write-length checker
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt           <= '0;
            err_addr          <= '0;
            err_is_wr         <= 1'b0;
            err_wlen_mismatch <= 1'b0;
            wlen_q            <= '0;
            wbeats_q          <= '0;
        end else begin
            err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (aw_push) begin
                err_addr  <= bus.awaddr;
                err_is_wr <= 1'b1;
            end else if (ar_push) begin
                err_addr  <= bus.araddr;
                err_is_wr <= 1'b0;
            end
            if (aw_pop) begin
                wlen_q   <= aw_head.len;
                wbeats_q <= '0;
            end else if (w_fire) begin
                // wbeats_q counts beats before this one; the last beat must be index awlen
                if (bus.wlast && (wbeats_q != (LEN_W+2)'(wlen_q))) begin
                    err_wlen_mismatch <= 1'b1;
                end
                if (!(&wbeats_q)) wbeats_q <= wbeats_q + (LEN_W+2)'(1);
            end
        end
    end
`else
    logic unused_log_inputs;
    assign unused_log_inputs = ^{bus.araddr, bus.awaddr, aw_head.len};
`endif

endmodule

// File: tb/tb_axi_default_slave_burst.sv
// Testbench for axi_default_slave_burst: directed scenarios followed by a
// randomized phase, all checked against a transaction-level scoreboard
// (expected R beats and B responses queued when AR/AW handshakes occur).
module tb_axi_default_slave_burst;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_default_slave_burst_if #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef DS_ERR_LOG_EN
    logic [15:0] err_cnt;
    logic [31:0] err_addr;
    logic        err_is_wr;
    logic        err_wlen_mismatch;
`endif

    axi_default_slave_burst #(
        .ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .OST_DEPTH(2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef DS_ERR_LOG_EN
        .err_cnt           (err_cnt),
        .err_addr          (err_addr),
        .err_is_wr         (err_is_wr),
        .err_wlen_mismatch (err_wlen_mismatch),
`endif
        .bus               (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            last;
    } rbeat_t;

    rbeat_t          rq[$];      // expected R beats in order
    logic [ID_W-1:0] bq[$];      // expected B ids in order
    int              wlen_q[$];  // awlen of write bursts still owing data
    int              w_sent = 0;

    logic            s_rvalid, s_rlast, s_bvalid, s_wready, s_arready, s_awready;
    logic [ID_W-1:0] s_rid, s_bid, s_arid, s_awid;
    logic [LEN_W-1:0] s_arlen, s_awlen;
    logic            s_wlast;
    logic            ar_fire = 0, aw_fire = 0, r_fire = 0, w_fire = 0, b_fire = 0;
    logic            overlap = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at negedge, update the model at the edge.
    task automatic cyc();
        @(negedge clk);
        s_rvalid  = bus.rvalid;  s_rlast  = bus.rlast;  s_rid = bus.rid;
        s_bvalid  = bus.bvalid;  s_bid    = bus.bid;    s_wready = bus.wready;
        s_arready = bus.arready; s_awready = bus.awready;
        s_arid = bus.arid; s_arlen = bus.arlen; s_awid = bus.awid; s_awlen = bus.awlen;
        s_wlast = bus.wlast;
        ar_fire = bus.arvalid && bus.arready;
        aw_fire = bus.awvalid && bus.awready;
        r_fire  = bus.rvalid && bus.rready;
        w_fire  = bus.wvalid && bus.wready;
        b_fire  = bus.bvalid && bus.bready;
        if (s_rvalid && s_bvalid) overlap = 1'b1;
        if (!rst) begin
            if (s_rvalid) begin
                chk("r_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    chk("rid",   64'(s_rid),     64'(rq[0].id));
                    chk("rlast", 64'(s_rlast),   64'(rq[0].last));
                    chk("rresp", 64'(bus.rresp), 64'd3);
                    chk("rdata", 64'(bus.rdata), 64'd0);
                end
            end
            if (s_bvalid) begin
                chk("b_expected", 64'(bq.size() != 0), 64'd1);
                if (bq.size() != 0) begin
                    chk("bid",   64'(s_bid),     64'(bq[0]));
                    chk("bresp", 64'(bus.bresp), 64'd3);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            rq.delete(); bq.delete(); wlen_q.delete(); w_sent = 0;
        end else begin
            if (r_fire && rq.size() != 0) rq.delete(0);
            if (b_fire && bq.size() != 0) bq.delete(0);
            if (ar_fire)
                for (int i = 0; i <= int'(s_arlen); i++)
                    rq.push_back('{id: s_arid, last: (i == int'(s_arlen))});
            if (aw_fire) begin
                bq.push_back(s_awid);
                wlen_q.push_back(int'(s_awlen));
            end
            if (w_fire && wlen_q.size() != 0) begin
                if (s_wlast) begin wlen_q.delete(0); w_sent = 0; end
                else w_sent++;
            end
        end
        #1;
    endtask

    // Present W beats for bursts whose AW is accepted; wlast on beat index awlen.
    task automatic drive_w(input bit gate);
        if (!bus.wvalid || w_fire) bus.wvalid = (wlen_q.size() != 0) && gate;
        bus.wlast = bus.wvalid ? (w_sent == wlen_q[0]) : 1'b0;
    endtask

    task automatic drive_rand(input bit gen);
        if (!bus.arvalid || ar_fire) begin
            bus.arvalid = gen && ($urandom_range(0, 2) == 0);
            bus.arid    = ID_W'($urandom);
            bus.arlen   = ($urandom_range(0, 7) == 0) ? 4'hF : LEN_W'($urandom_range(0, 3));
            bus.araddr  = $urandom;
        end
        if (!bus.awvalid || aw_fire) begin
            bus.awvalid = gen && ($urandom_range(0, 2) == 0);
            bus.awid    = ID_W'($urandom);
            bus.awlen   = LEN_W'($urandom_range(0, 3));
            bus.awaddr  = $urandom;
        end
        drive_w($urandom_range(0, 3) != 0);
        bus.rready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.bready = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic do_reset();
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.wlast = 0;
        bus.rready = 0; bus.bready = 0;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        logic [ID_W-1:0]  t2_id[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [LEN_W-1:0] t2_len[4] = '{4'd1, 4'd0, 4'd2, 4'd1};

        bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
        do_reset();

        // Reset state
        chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
        chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
        chk("rst_wready",  64'(bus.wready),  64'd0);
        chk("rst_rlast",   64'(bus.rlast),   64'd0);
        chk("rst_rid",     64'(bus.rid),     64'd0);
        chk("rst_bid",     64'(bus.bid),     64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_awready", 64'(bus.awready), 64'd1);
`ifdef DS_ERR_LOG_EN
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif

        // W beats without any AW are stalled
        bus.wvalid = 1; bus.wlast = 1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("w_stall_wready", 64'(s_wready), 64'd0);
        end
        bus.wvalid = 0; bus.wlast = 0;

        // T1: single AR id=5 len=3, first rvalid two cycles after acceptance
        bus.arvalid = 1; bus.arid = 8'd5; bus.arlen = 4'd3; bus.rready = 1;
        cyc();
        chk("t1_ar_accept", 64'(ar_fire), 64'd1);
        bus.arvalid = 0;
        cyc();
        chk("t1_rvalid_c1", 64'(s_rvalid), 64'd0);
        cyc();
        chk("t1_rvalid_c2", 64'(s_rvalid), 64'd1);
        for (int k = 0; k < 20 && rq.size() != 0; k++) cyc();
        chk("t1_drain", 64'(rq.size()), 64'd0);
        cyc();
        chk("t1_idle_rvalid", 64'(s_rvalid), 64'd0);

        // T2: back-to-back ARs with rready=0; engine holds one, FIFO holds two
        bus.rready = 0;
        nxt = 0;
        for (int k = 0; k < 8; k++) begin
            bus.arvalid = (nxt < 4);
            if (nxt < 4) begin bus.arid = t2_id[nxt]; bus.arlen = t2_len[nxt]; end
            cyc();
            if (ar_fire) nxt++;
        end
        chk("t2_accepted", 64'(nxt), 64'd3);
        chk("t2_arready_low", 64'(s_arready), 64'd0);
        bus.rready = 1;
        for (int k = 0; k < 40 && (nxt < 4 || rq.size() != 0); k++) begin
            bus.arvalid = (nxt < 4);
            if (nxt < 4) begin bus.arid = t2_id[nxt]; bus.arlen = t2_len[nxt]; end
            cyc();
            if (ar_fire) nxt++;
        end
        bus.arvalid = 0;
        chk("t2_all_accepted", 64'(nxt), 64'd4);
        chk("t2_drain", 64'(rq.size()), 64'd0);

        // T3: AW id=9 len=1, two W beats, B held off for three cycles
        bus.awvalid = 1; bus.awid = 8'd9; bus.awlen = 4'd1; bus.bready = 0;
        cyc();
        chk("t3_aw_accept", 64'(aw_fire), 64'd1);
        bus.awvalid = 0;
        for (int k = 0; k < 12 && !bus.bvalid; k++) begin
            drive_w(1'b1);
            cyc();
        end
        drive_w(1'b1);
        chk("t3_w_done", 64'(wlen_q.size()), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_bvalid_hold", 64'(s_bvalid), 64'd1);
            chk("t3_bid_hold",    64'(s_bid),    64'd9);
        end
        bus.bready = 1;
        cyc();
        chk("t3_b_fire", 64'(b_fire), 64'd1);
        cyc();
        chk("t3_bvalid_low", 64'(s_bvalid), 64'd0);
`ifdef DS_ERR_LOG_EN
        chk("t3_no_mismatch", 64'(err_wlen_mismatch), 64'd0);
`endif

        // T4: AR len=15 and AW in the same cycle, responses overlap
        overlap = 0;
        bus.arvalid = 1; bus.arid = 8'h3C; bus.arlen = 4'hF;
        bus.awvalid = 1; bus.awid = 8'h7A; bus.awlen = 4'd2;
        bus.rready = 1; bus.bready = 1;
        cyc();
        chk("t4_ar_accept", 64'(ar_fire), 64'd1);
        chk("t4_aw_accept", 64'(aw_fire), 64'd1);
        chk("t4_beats_queued", 64'(rq.size()), 64'd16);
        bus.arvalid = 0; bus.awvalid = 0;
        for (int k = 0; k < 60 && (rq.size() != 0 || bq.size() != 0 || wlen_q.size() != 0); k++) begin
            drive_w(1'b1);
            cyc();
        end
        drive_w(1'b1);
        chk("t4_r_drain", 64'(rq.size()), 64'd0);
        chk("t4_b_drain", 64'(bq.size()), 64'd0);
        chk("t4_overlap", 64'(overlap), 64'd1);

        // T5: reset asserted during beat 2 of a 4-beat burst
        bus.arvalid = 1; bus.arid = 8'h66; bus.arlen = 4'd3; bus.rready = 1;
        cyc();
        bus.arvalid = 0;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("t5_beat2_seen", 64'(s_rvalid), 64'd1);
        chk("t5_rvalid_after_rst", 64'(bus.rvalid), 64'd0);
        chk("t5_rid_after_rst",    64'(bus.rid),    64'd0);
        chk("t5_rlast_after_rst",  64'(bus.rlast),  64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t5_arready", 64'(s_arready), 64'd1);
            chk("t5_no_rvalid", 64'(s_rvalid), 64'd0);
            chk("t5_no_rlast", 64'(s_rlast), 64'd0);
        end

        // Randomized traffic on all channels
        for (int k = 0; k < 600; k++) begin
            drive_rand(1'b1);
            cyc();
        end
        for (int k = 0; k < 400 && (bus.arvalid || bus.awvalid || rq.size() != 0 ||
                                    bq.size() != 0 || wlen_q.size() != 0); k++) begin
            drive_rand(1'b0);
            cyc();
        end
        bus.arvalid = 0; bus.awvalid = 0;
        chk("rand_r_drain", 64'(rq.size()), 64'd0);
        chk("rand_b_drain", 64'(bq.size()), 64'd0);
        chk("rand_w_drain", 64'(wlen_q.size()), 64'd0);

`ifdef DS_ERR_LOG_EN
        // Error log: one AR then one AW
        do_reset();
        bus.arvalid = 1; bus.araddr = 32'hDEAD_0000; bus.arid = 8'h01; bus.arlen = 4'd0;
        cyc();
        bus.arvalid = 0;
        bus.awvalid = 1; bus.awaddr = 32'hBEEF_0000; bus.awid = 8'h02; bus.awlen = 4'd0;
        cyc();
        bus.awvalid = 0;
        chk("log_cnt",   64'(err_cnt),   64'd2);
        chk("log_addr",  64'(err_addr),  64'hBEEF_0000);
        chk("log_is_wr", 64'(err_is_wr), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
